// File: rtl/lane_queue_tracker_pkg.sv
// Shared sizing, pacing defaults and lane light-state encoding for the lane queue tracker.
package lane_queue_tracker_pkg;
  localparam int LANES   = 8;
  localparam int WIDTH   = 8;
  localparam int STARTUP = 4;
  localparam int HEADWAY = 2;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    START = 2'd1,
    FLOW  = 2'd2
  } lane_state_e;
endpackage

// File: rtl/lane_queue.sv
// One lane: sensor synchronizer and edge detect, green-light pacing FSM, saturating
// car counter and sticky overflow flag.
module lane_queue
  import lane_queue_tracker_pkg::*;
#(
  parameter int CNT_W       = WIDTH,
  parameter int STARTUP_CYC = STARTUP,
  parameter int HEADWAY_CYC = HEADWAY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor,
  input  logic             green,
  input  logic             clr_overflow,
  output logic [CNT_W-1:0] count,
  output logic             depart_pulse,
  output logic             overflow
);

  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0] TMR_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0] TMR_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] START_LD = TIMER_W'(STARTUP_CYC - 1);
  localparam logic [TIMER_W-1:0] HW_LD    = TIMER_W'(HEADWAY_CYC - 1);

  logic               sync1_r, sync2_r, prev_r;
  logic               arrive_r, depart_r;
  lane_state_e        state_r;
  logic [TIMER_W-1:0] timer_r, hw_r;
  logic               arrive_s, depart_s;

  // A car already committed to leave (depart_r) is excluded so the queue cannot underflow.
  always_comb begin
    arrive_s = sync2_r & ~prev_r;
    depart_s = 1'b0;
    if ((state_r == FLOW) && green && (hw_r == TMR_ZERO)) begin
      depart_s = (count > {{(CNT_W-1){1'b0}}, depart_r});
    end else begin
      depart_s = 1'b0;
    end
  end

  // Synchronizer, event registers, counter, overflow flag and pacing FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      prev_r       <= 1'b0;
      arrive_r     <= 1'b0;
      depart_r     <= 1'b0;
      depart_pulse <= 1'b0;
      count        <= {CNT_W{1'b0}};
      overflow     <= 1'b0;
      state_r      <= RED;
      timer_r      <= TMR_ZERO;
      hw_r         <= TMR_ZERO;
    end else begin
      sync1_r      <= sensor;
      sync2_r      <= sync1_r;
      prev_r       <= sync2_r;
      arrive_r     <= arrive_s;
      depart_r     <= depart_s;
      depart_pulse <= depart_r;

      case ({arrive_r, depart_r})
        2'b10:   count <= (count == CNT_MAX) ? count : count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      if (arrive_r && !depart_r && (count == CNT_MAX)) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end

      if (!green) begin
        state_r <= RED;
      end else begin
        case (state_r)
          RED: begin
            state_r <= START;
            timer_r <= START_LD;
          end
          START: begin
            if (timer_r == TMR_ZERO) begin
              state_r <= FLOW;
              hw_r    <= TMR_ZERO;
            end else begin
              timer_r <= timer_r - TMR_ONE;
            end
          end
          FLOW: begin
            if (depart_s) begin
              hw_r <= HW_LD;
            end else if (hw_r != TMR_ZERO) begin
              hw_r <= hw_r - TMR_ONE;
            end else begin
              hw_r <= hw_r;
            end
          end
          default: state_r <= RED;
        endcase
      end
    end
  end

endmodule

// File: rtl/lane_queue_tracker.sv
// Per-lane waiting-car counters for all lanes, packed onto the bus read by lane selection.
module lane_queue_tracker
  import lane_queue_tracker_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       sensor,
  input  logic [LANES-1:0]       laneGreen,
  input  logic                   clrOverflow,
  output logic [LANES*WIDTH-1:0] lane,
  output logic [LANES-1:0]       departPulse,
  output logic [LANES-1:0]       overflow
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_queue #(
      .CNT_W      (WIDTH),
      .STARTUP_CYC(STARTUP),
      .HEADWAY_CYC(HEADWAY)
    ) u_lane_queue (
      .clk         (clk),
      .rst         (rst),
      .sensor      (sensor[i]),
      .green       (laneGreen[i]),
      .clr_overflow(clrOverflow),
      .count       (lane[i*WIDTH +: WIDTH]),
      .depart_pulse(departPulse[i]),
      .overflow    (overflow[i])
    );
  end

endmodule

// File: tb/tb_lane_queue_tracker.sv
// Directed bench for lane_queue_tracker; cycle k is the interval after rising edge k.
module tb_lane_queue_tracker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sensor = 8'd0;
  logic [7:0]  laneGreen = 8'd0;
  logic        clrOverflow = 1'b0;
  logic [63:0] lane;
  logic [7:0]  departPulse;
  logic [7:0]  overflow;
  int          n_checks = 0;
  int          n_pass = 0;

  lane_queue_tracker dut (
    .clk        (clk),
    .rst        (rst),
    .sensor     (sensor),
    .laneGreen  (laneGreen),
    .clrOverflow(clrOverflow),
    .lane       (lane),
    .departPulse(departPulse),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] lane_count(input int i);
    return {56'd0, lane[i*8 +: 8]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sensor(input logic [7:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      sensor = sensor | mask;
      cyc(2);
      sensor = sensor & ~mask;
      cyc(2);
    end
    cyc(4);
  endtask

  initial begin
    cyc(2);
    check_value("reset_lane", lane, 64'd0);
    check_value("reset_pulse", {56'd0, departPulse}, 64'd0);
    check_value("reset_ovf", {56'd0, overflow}, 64'd0);
    rst = 1'b0;
    cyc(2);

    // Arrival latency and single count for a held level.
    sensor[2] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      check_value($sformatf("arrive_c%0d", c), lane_count(2), (c >= 3) ? 64'd1 : 64'd0);
    end
    sensor[2] = 1'b0;
    cyc(3);
    sensor[2] = 1'b1;
    cyc(6);
    check_value("arrive_second", lane_count(2), 64'd2);
    sensor[2] = 1'b0;
    cyc(3);

    // Drain lane 4 from 3; lane 5 green but empty.
    pulse_sensor(8'h10, 3);
    check_value("drain_preload", lane_count(4), 64'd3);
    laneGreen = 8'h30;
    for (int c = 0; c < 14; c++) begin
      cyc(1);
      check_value($sformatf("drain_cnt_c%0d", c), lane_count(4),
                  (c < 6) ? 64'd3 : (c < 8) ? 64'd2 : (c < 10) ? 64'd1 : 64'd0);
      check_value($sformatf("drain_pulse4_c%0d", c), {63'd0, departPulse[4]},
                  (c == 6 || c == 8 || c == 10) ? 64'd1 : 64'd0);
      check_value($sformatf("drain_pulse5_c%0d", c), {63'd0, departPulse[5]}, 64'd0);
    end
    laneGreen = 8'h00;
    cyc(2);

    // Green dropped mid-drain, then re-green restarts the start-up delay.
    pulse_sensor(8'h40, 4);
    laneGreen = 8'h40;
    for (int c = 0; c < 13; c++) begin
      cyc(1);
      check_value($sformatf("drop_cnt_c%0d", c), lane_count(6),
                  (c < 6) ? 64'd4 : (c < 8) ? 64'd3 : 64'd2);
      check_value($sformatf("drop_pulse_c%0d", c), {63'd0, departPulse[6]},
                  (c == 6 || c == 8) ? 64'd1 : 64'd0);
      if (c == 7) laneGreen = 8'h00;
    end
    laneGreen = 8'h40;
    for (int c = 0; c < 7; c++) begin
      cyc(1);
      check_value($sformatf("regreen_cnt_c%0d", c), lane_count(6), (c < 6) ? 64'd2 : 64'd1);
      check_value($sformatf("regreen_pulse_c%0d", c), {63'd0, departPulse[6]},
                  (c == 6) ? 64'd1 : 64'd0);
    end
    laneGreen = 8'h00;
    cyc(2);

    // Arrival coinciding with a departure leaves the count unchanged.
    pulse_sensor(8'h02, 8);
    laneGreen = 8'h02;
    for (int c = 0; c < 9; c++) begin
      cyc(1);
      if (c == 5) check_value("simul_c5", lane_count(1), 64'd8);
      if (c == 6) check_value("simul_c6", lane_count(1), 64'd7);
      if (c == 8) begin
        check_value("simul_cnt", lane_count(1), 64'd7);
        check_value("simul_pulse", {63'd0, departPulse[1]}, 64'd1);
      end
      if (c == 4) sensor[1] = 1'b1;
    end
    laneGreen = 8'h00;
    sensor[1] = 1'b0;
    cyc(4);

    // Saturation and overflow set/clear priority.
    pulse_sensor(8'h08, 255);
    check_value("sat_fill", lane_count(3), 64'd255);
    check_value("sat_ovf0", {63'd0, overflow[3]}, 64'd0);
    pulse_sensor(8'h08, 1);
    check_value("sat_hold", lane_count(3), 64'd255);
    check_value("sat_ovf1", {63'd0, overflow[3]}, 64'd1);
    sensor[3] = 1'b1;
    cyc(3);
    clrOverflow = 1'b1;
    cyc(1);
    clrOverflow = 1'b0;
    check_value("sat_setwins", {63'd0, overflow[3]}, 64'd1);
    check_value("sat_cnt2", lane_count(3), 64'd255);
    sensor[3] = 1'b0;
    cyc(3);
    clrOverflow = 1'b1;
    cyc(1);
    clrOverflow = 1'b0;
    check_value("sat_clr", {63'd0, overflow[3]}, 64'd0);
    check_value("sat_cnt3", lane_count(3), 64'd255);

    // Asynchronous reset in the middle of a drain.
    pulse_sensor(8'h01, 5);
    laneGreen = 8'h01;
    cyc(8);
    check_value("rst_pre", lane_count(0), 64'd4);
    #2 rst = 1'b1;
    #1;
    check_value("rst_async_lane", lane, 64'd0);
    check_value("rst_async_pulse", {56'd0, departPulse}, 64'd0);
    check_value("rst_async_ovf", {56'd0, overflow}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sensor[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      cyc(1);
      check_value($sformatf("rst_cnt_c%0d", c), lane_count(0),
                  (c < 3) ? 64'd0 : (c < 6) ? 64'd1 : 64'd0);
      check_value($sformatf("rst_pulse_c%0d", c), {63'd0, departPulse[0]},
                  (c == 6) ? 64'd1 : 64'd0);
    end
    sensor[0] = 1'b0;
    laneGreen = 8'h00;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lane_queue_tracker.md
Name: lane_queue_tracker

Overview:
Produces the per-lane waiting-car counts that the daytime lane-selection logic consumes, and consumes that logic's 8-bit green-light vector in return. Each lane counts arrivals from a raw vehicle sensor and counts departures while its light is green. Departures are paced by a start-up delay and a headway timer, so queues drain realistically. The lane count bus feeds the lane-selection block directly, closing the control loop.

Parameters:
LANES, 8, number of lanes (N1,N2,E1,E2,S1,S2,W1,W2 at indices 0..7)
WIDTH, 8, bits per lane count
STARTUP, 4, cycles from green sampled to first departure eligibility (>=1)
HEADWAY, 2, minimum cycles between consecutive departures in one lane (>=1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
sensor  in  LANES  raw asynchronous vehicle-present level per lane; each rising edge = one arrival
laneGreen  in  LANES  green-light vector from the lane-selection block, bit i = lane i green
clrOverflow  in  1  synchronous clear of all overflow flags
lane  out  LANES*WIDTH  count of lane i at bits [i*WIDTH +: WIDTH]; registered
departPulse  out  LANES  one-cycle pulse, aligned with the lane count update that removed a car
overflow  out  LANES  sticky flag: an arrival was dropped at saturation

Behaviour:
- Reset (async, any time, including mid-drain) sets all of the following to zero or idle: lane=0, departPulse=0, overflow=0, sync flops=0, all lane FSMs=RED, all timers=0.
- Arrival path: sensor passes through a 2-flop synchronizer and then a prev flop.
  - arrive = sync2 & ~prev.
  - sensor rising before edge 0 -> arrive high in cycle 2 -> count +1 visible in cycle 3.
  - A level held high counts exactly once.
- Per-lane FSM states: RED, START, FLOW.
  - RED: on laneGreen[i]=1 -> START, timer=STARTUP-1.
  - START: timer decrements each cycle; at timer==0 -> FLOW, headway timer=0.
  - FLOW: depart = laneGreen[i] & (hw==0) & (count>0).
    - If depart: hw reloads HEADWAY-1.
    - Else if hw>0: hw decrements.
    - hw==0 with count==0: wait at 0, no pulse.
  - Any state with laneGreen[i]=0 -> RED next cycle; no departure occurs in that cycle.
- Departure timing: green first sampled in cycle 0 -> first decrement visible with departPulse high in cycle STARTUP+2. Subsequent departures follow every HEADWAY cycles while green and count>0.
  - Defaults: departures at cycles 6, 8, 10, ...
- Count update, evaluated each cycle:
  - arrive & depart -> count unchanged, departPulse asserted.
  - arrive only at count=2^WIDTH-1 -> count holds, overflow[i] set.
  - arrive only below max -> count+1.
  - depart only -> count-1 (never underflows; depart requires count>0).
- overflow: set wins over clrOverflow in the same cycle; otherwise clrOverflow clears it.
- Lanes are fully independent; several lanes may be green at once.

Decomposition:
- Shared package holds LANES, WIDTH, STARTUP/HEADWAY defaults, and the lane FSM state enum {RED, START, FLOW}.
- One sub-module, lane_queue: a single lane's synchronizer, edge detect, FSM, timers, counter and overflow flag.
- lane_queue_tracker instantiates LANES copies of lane_queue and packs their outputs onto the lane bus.

Test Plan:
- Reset mid-drain: lane 0 count=5, green=1, assert rst asynchronously -> all outputs 0 immediately, FSM RED; release rst -> new departures only STARTUP+2 cycles after green is next sampled.
- Arrival latency: sensor[2] rises before edge 0 and is held 20 cycles -> lane[23:16] becomes 1 in cycle 3 and stays 1; a second rising edge -> 2.
- Drain: lane 4 preloaded to 3, laneGreen=8'b00110000 from cycle 0 -> lane 4 count 2,1,0 at cycles 6, 8, 10 with departPulse[4] in those cycles; nothing afterwards; lane 5 (count 0) never pulses.
- Green dropped mid-drain: lane 6 count 4, green cycles 0-7 -> decrements at cycles 6 and 8 only; count 2 retained; re-green restarts the STARTUP delay.
- Simultaneous events: lane 1 in FLOW with count 7, arrival edge in a departure cycle -> count stays 7 and departPulse[1]=1.
- Saturation: lane 3 at 255, one arrival -> count 255, overflow[3]=1; clrOverflow together with another arrival -> overflow stays 1; clrOverflow alone -> 0.
